// File: rtl/push_button_conditioner_pkg.sv
// Shared constants for the push-button input path: button indices,
// default sizes and counter limits for the 100 MHz oscillator.
package push_button_conditioner_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_MID   = 4;

    localparam int N_BTN_DEF           = 5;
    localparam int CNT_W_DEF           = 20;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int REPEAT_DELAY_DEF    = 50_000_000;
    localparam int REPEAT_PERIOD_DEF   = 20_000_000;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/push_button_conditioner_if.sv
// Button event stream: one pending press offered per cycle with
// valid/ready handshake, plus a lost-press indication.
interface push_button_conditioner_if #(
    parameter int ID_W = 3
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_overrun;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_overrun,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_overrun,
        output evt_ready
    );
endinterface

// File: rtl/push_button_conditioner_debounce.sv
// One button: 2-flop sync, counter debounce, press/release pulses.
// Optional hold auto-repeat when PUSH_AUTOREPEAT_EN is defined.
module button_debounce_cell #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 20_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic press,
    output logic fall
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

`ifdef PUSH_AUTOREPEAT_EN
    // Repeat delays can exceed the debounce counter range, so widen as needed.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = ($clog2(RPT_MAX + 1) > CNT_W) ? $clog2(RPT_MAX + 1) : CNT_W;

    logic [RPT_W-1:0] rcnt;
    logic             first;
    logic [RPT_W-1:0] rlim;

    assign rlim = first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            fall  <= 1'b0;
`ifdef PUSH_AUTOREPEAT_EN
            rcnt  <= '0;
            first <= 1'b1;
`endif
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            fall  <= 1'b0;
`ifdef PUSH_AUTOREPEAT_EN
            // Placed first so a coinciding release below overrides the repeat.
            if (!level) begin
                rcnt  <= '0;
                first <= 1'b1;
            end else if (rcnt == rlim) begin
                rcnt  <= '0;
                first <= 1'b0;
                press <= 1'b1;
            end else begin
                rcnt  <= rcnt + 1'b1;
            end
`endif
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= s2;
                press <= s2;
                fall  <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/push_button_conditioner.sv
// Push-button conditioner: per-button debounce cells, pending-press
// register, lowest-index pick and a single-entry event slot.
module push_button_conditioner
    import push_button_conditioner_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [N_BTN-1:0]           btn_raw,
    output logic [N_BTN-1:0]           btn_level,
    output logic [N_BTN-1:0]           btn_press,
    output logic [N_BTN-1:0]           btn_release,
    push_button_conditioner_if.master  evt
);

    localparam int ID_W = id_w(N_BTN);

    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] pick_oh;
    logic [N_BTN-1:0] clr;
    logic [ID_W-1:0]  pick_id;
    logic             load;
    logic             slot_valid;
    logic [ID_W-1:0]  slot_id;
    logic             overrun;

    for (genvar i = 0; i < N_BTN; i++) begin : g_cell
        button_debounce_cell #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_cell (
            .clk    (clk),
            .resetn (resetn),
            .raw    (btn_raw[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i]),
            .fall   (btn_release[i])
        );
    end

    // Descending scan so the lowest set index wins.
    always_comb begin
        pick_id = '0;
        pick_oh = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pick_id = ID_W'(i);
                pick_oh = N_BTN'(1) << i;
            end
        end
    end

    assign load = !slot_valid || evt.evt_ready;
    assign clr  = load ? pick_oh : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend       <= '0;
            slot_valid <= 1'b0;
            slot_id    <= '0;
            overrun    <= 1'b0;
        end else begin
            pend    <= (pend & ~clr) | btn_press;
            overrun <= |(btn_press & pend & ~clr);
            if (load) begin
                slot_valid <= |pend;
                if (|pend) slot_id <= pick_id;
            end
        end
    end

    assign evt.evt_valid   = slot_valid;
    assign evt.evt_id      = slot_id;
    assign evt.evt_overrun = overrun;

endmodule

// File: tb/tb_push_button_conditioner.sv
// Directed bench for push_button_conditioner with short debounce/repeat
// limits; repeat expectations follow PUSH_AUTOREPEAT_EN.
module tb_push_button_conditioner;
    import push_button_conditioner_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] btn_raw;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;

    int n_chk  = 0;
    int n_fail = 0;

    push_button_conditioner_if #(.ID_W(3)) evt ();

    push_button_conditioner #(
        .N_BTN           (5),
        .CNT_W           (8),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .btn_raw     (btn_raw),
        .btn_level   (lvl),
        .btn_press   (prs),
        .btn_release (rel),
        .evt         (evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int          cnt;
        logic        pat [8];
        logic [31:0] exp_rep;

        resetn          = 1'b0;
        btn_raw         = '0;
        evt.evt_ready   = 1'b0;
        #12;
        chk("rst_level", 32'(lvl), 0);
        chk("rst_press", 32'(prs), 0);
        chk("rst_valid", 32'(evt.evt_valid), 0);
        chk("rst_overrun", 32'(evt.evt_overrun), 0);
        tick(2);
        resetn = 1'b1;
        tick(2);

        // single press on UP
        btn_raw[BTN_UP] = 1'b1;
        tick(5);
        chk("t1_level_early", 32'(lvl), 0);
        tick();
        chk("t1_level", 32'(lvl), 32'h01);
        chk("t1_press", 32'(prs), 32'h01);
        chk("t1_valid_t0", 32'(evt.evt_valid), 0);
        tick();
        chk("t1_press_gone", 32'(prs), 0);
        chk("t1_valid_t1", 32'(evt.evt_valid), 0);
        tick();
        chk("t1_valid_t2", 32'(evt.evt_valid), 1);
        chk("t1_id", 32'(evt.evt_id), 0);
        evt.evt_ready = 1'b1;
        tick();
        chk("t1_drained", 32'(evt.evt_valid), 0);
        evt.evt_ready = 1'b0;
        btn_raw = '0;
        tick(6);
        chk("t1_release", 32'(rel), 32'h01);
        chk("t1_level_low", 32'(lvl), 0);
        tick();
        chk("t1_release_gone", 32'(rel), 0);

        // bouncing LEFT then steady
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            btn_raw[BTN_LEFT] = pat[i];
            tick();
            cnt += int'(prs[BTN_LEFT]);
        end
        btn_raw[BTN_LEFT] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(prs[BTN_LEFT]);
        end
        chk("t2_bounce_presses", 32'(cnt), 1);
        chk("t2_level", 32'(lvl), 32'h04);
        chk("t2_valid", 32'(evt.evt_valid), 1);
        chk("t2_id", 32'(evt.evt_id), 2);
        evt.evt_ready = 1'b1;
        tick();
        evt.evt_ready = 1'b0;
        chk("t2_drained", 32'(evt.evt_valid), 0);
        btn_raw = '0;
        tick(8);
        chk("t2_level_low", 32'(lvl), 0);
        cnt = 0;
        btn_raw[BTN_LEFT] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt += int'(prs[BTN_LEFT]);
        end
        btn_raw = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(prs[BTN_LEFT]);
        end
        chk("t2_glitch_presses", 32'(cnt), 0);
        chk("t2_glitch_level", 32'(lvl), 0);

        // simultaneous presses drain in ascending order
        evt.evt_ready = 1'b1;
        btn_raw = 5'b10110;
        tick(6);
        chk("t3_press", 32'(prs), 32'h16);
        tick();
        chk("t3_valid_t1", 32'(evt.evt_valid), 0);
        tick();
        chk("t3_valid_a", 32'(evt.evt_valid), 1);
        chk("t3_id_a", 32'(evt.evt_id), 1);
        tick();
        chk("t3_valid_b", 32'(evt.evt_valid), 1);
        chk("t3_id_b", 32'(evt.evt_id), 2);
        tick();
        chk("t3_valid_c", 32'(evt.evt_valid), 1);
        chk("t3_id_c", 32'(evt.evt_id), 4);
        tick();
        chk("t3_empty", 32'(evt.evt_valid), 0);
        btn_raw = '0;
        evt.evt_ready = 1'b0;
        tick(8);

        // stalled consumer: pend, then overrun
        btn_raw[BTN_RIGHT] = 1'b1;
        tick(6);
        chk("t4_press1", 32'(prs), 32'h08);
        tick(2);
        chk("t4_valid", 32'(evt.evt_valid), 1);
        chk("t4_id", 32'(evt.evt_id), 3);
        btn_raw = '0;
        tick(8);
        btn_raw[BTN_RIGHT] = 1'b1;
        tick(6);
        chk("t4_press2", 32'(prs), 32'h08);
        tick();
        chk("t4_no_overrun", 32'(evt.evt_overrun), 0);
        chk("t4_id_stable", 32'(evt.evt_id), 3);
        btn_raw = '0;
        tick(8);
        btn_raw[BTN_RIGHT] = 1'b1;
        tick(6);
        chk("t4_press3", 32'(prs), 32'h08);
        tick();
        chk("t4_overrun", 32'(evt.evt_overrun), 1);
        chk("t4_id_held", 32'(evt.evt_id), 3);
        tick();
        chk("t4_overrun_pulse", 32'(evt.evt_overrun), 0);
        evt.evt_ready = 1'b1;
        tick();
        chk("t4_pend_valid", 32'(evt.evt_valid), 1);
        chk("t4_pend_id", 32'(evt.evt_id), 3);
        tick();
        chk("t4_empty", 32'(evt.evt_valid), 0);
        evt.evt_ready = 1'b0;
        btn_raw = '0;
        tick(8);

        // async reset mid-debounce with a full slot
        btn_raw = 5'b00001;
        tick(8);
        chk("t5_valid_pre", 32'(evt.evt_valid), 1);
        btn_raw = 5'b00011;
        tick(2);
        resetn = 1'b0;
        #1;
        chk("t5_rst_level", 32'(lvl), 0);
        chk("t5_rst_press", 32'(prs), 0);
        chk("t5_rst_release", 32'(rel), 0);
        chk("t5_rst_valid", 32'(evt.evt_valid), 0);
        chk("t5_rst_id", 32'(evt.evt_id), 0);
        chk("t5_rst_overrun", 32'(evt.evt_overrun), 0);
        tick(2);
        resetn = 1'b1;
        tick(5);
        chk("t5_level_early", 32'(lvl), 0);
        tick();
        chk("t5_level", 32'(lvl), 32'h03);
        chk("t5_press", 32'(prs), 32'h03);
        tick(2);
        chk("t5_valid", 32'(evt.evt_valid), 1);
        chk("t5_id", 32'(evt.evt_id), 0);
        evt.evt_ready = 1'b1;
        tick();
        chk("t5_id_next", 32'(evt.evt_id), 1);
        tick();
        chk("t5_empty", 32'(evt.evt_valid), 0);
        btn_raw = '0;
        tick(8);

        // hold MID: auto-repeat only when enabled
        btn_raw[BTN_MID] = 1'b1;
        tick(6);
        chk("t6_press", 32'(prs), 32'h10);
        for (int k = 1; k < 30; k++) begin
            tick();
`ifdef PUSH_AUTOREPEAT_EN
            exp_rep = (k == 10 || k == 15 || k == 20 || k == 25) ? 32'h10 : 32'h0;
`else
            exp_rep = 32'h0;
`endif
            chk($sformatf("t6_repeat_%0d", k), 32'(prs), exp_rep);
        end
        chk("t6_no_overrun", 32'(evt.evt_overrun), 0);
        btn_raw = '0;
        tick(8);
        chk("t6_level_low", 32'(lvl), 0);
        evt.evt_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
